// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants, types and helpers for the data-memory arbiter and the
// round-robin arbiter that is also reused by the bank write-port scheduler.
package data_mem_arbiter_pkg;

    localparam int DATA_MEM_ADDR_L = 8;
    localparam int DATA_BIT_L      = 16;
    localparam int DATA_MEM_RD_LAT = 2;
    localparam int N_MEM_REQ       = 4;
    localparam int MEM_IDX_L       = (N_MEM_REQ > 1) ? $clog2(N_MEM_REQ) : 1;

    typedef logic [DATA_BIT_L-1:0] word_t;

    typedef struct packed {
        logic                       we;
        logic [DATA_MEM_ADDR_L-1:0] addr;
        word_t                      wr_data;
    } mem_req_t;

    typedef struct packed {
        logic                 vld;
        logic [MEM_IDX_L-1:0] idx;
    } mem_tag_t;

    // Explicit wrap so a non-power-of-two requester count is legal.
    function automatic int rr_next_ptr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from the priority
// pointer; the pointer moves past the winner when the caller takes the grant.
module rr_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic             hold_i,
    input  logic             upd_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] ptr_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;
    int               pos;

    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!found && !hold_i && req_i[pos[IDX_W-1:0]]) begin
                gnt_o[pos[IDX_W-1:0]] = 1'b1;
                gnt_idx               = pos[IDX_W-1:0];
                found                 = 1'b1;
            end
        end
        ptr_d = IDX_W'(rr_next_ptr(int'(gnt_idx), N_REQ));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (upd_i && found) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between N_REQ requesters: round-robin
// grant, registered memory command, and a read-tag pipeline routing responses.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_MEM_REQ,
    parameter int ADDR_L = DATA_MEM_ADDR_L,
    parameter int BIT_L  = DATA_BIT_L,
    parameter int RD_LAT = DATA_MEM_RD_LAT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             req_vld_i,
    input  logic [N_REQ-1:0]             req_we_i,
    input  logic [N_REQ-1:0][ADDR_L-1:0] req_addr_i,
    input  logic [N_REQ-1:0][BIT_L-1:0]  req_wr_data_i,
    output logic [N_REQ-1:0]             req_rdy_o,
    input  logic                         hold_i,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [ADDR_L-1:0]            mem_addr_o,
    output logic [BIT_L-1:0]             mem_wr_data_o,
    input  logic [BIT_L-1:0]             mem_rd_data_i,
    output logic [N_REQ-1:0]             rsp_vld_o,
    output logic [BIT_L-1:0]             rsp_data_o,
    output logic                         busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_L-1:0] addr;
        logic [BIT_L-1:0]  wr_data;
    } cmd_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic             accept;
    logic             unused_ptr;

    cmd_t             cmd_q, cmd_d;
    logic             en_q, en_d;
    tag_t [RD_LAT:0]  tag_q, tag_d;
    tag_t             tag_new;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [BIT_L-1:0] rsp_data_q, rsp_data_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_vld_i),
        .hold_i (hold_i),
        .upd_i  (accept),
        .gnt_o  (gnt),
        .ptr_o  (ptr)
    );

    // The pointer is only consumed by the bank scheduler instance.
    assign unused_ptr = ^ptr;
    assign req_rdy_o  = gnt;
    assign accept     = |gnt;

    always_comb begin
        sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) sel = IDX_W'(k);
        end
    end

    always_comb begin
        en_d   = accept;
        cmd_d  = cmd_q;
        cmd_d.we = 1'b0;
        if (accept) begin
            cmd_d.we      = req_we_i[sel];
            cmd_d.addr    = req_addr_i[sel];
            cmd_d.wr_data = req_wr_data_i[sel];
        end

        tag_new.vld = accept & ~req_we_i[sel];
        tag_new.idx = sel;
        tag_d[0]    = tag_new;
        for (int k = 1; k <= RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        // Last tag stage lines up with the memory's read data.
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        if (tag_q[RD_LAT].vld) begin
            rsp_vld_d[tag_q[RD_LAT].idx] = 1'b1;
            rsp_data_d                   = mem_rd_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q      <= '0;
            en_q       <= 1'b0;
            tag_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            cmd_q      <= cmd_d;
            en_q       <= en_d;
            tag_q      <= tag_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        busy_o = en_q;
        for (int k = 0; k <= RD_LAT; k++) begin
            busy_o = busy_o | tag_q[k].vld;
        end
    end

    assign mem_en_o      = en_q;
    assign mem_we_o      = cmd_q.we;
    assign mem_addr_o    = cmd_q.addr;
    assign mem_wr_data_o = cmd_q.wr_data;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_data_o    = rsp_data_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (N_REQ=4, RD_LAT=2) with a small
// read-first, two-cycle-latency memory model.
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          req_vld, req_we, req_rdy, rsp_vld;
    logic [N-1:0][AW-1:0]  req_addr;
    logic [N-1:0][DW-1:0]  req_wr_data;
    logic                  hold, mem_en, mem_we, busy;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wr_data, mem_rd_data, rsp_data, rd_p1;
    logic [DW-1:0]         mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.N_REQ(N), .ADDR_L(AW), .BIT_L(DW), .RD_LAT(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_vld_i     (req_vld),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wr_data_i (req_wr_data),
        .req_rdy_o     (req_rdy),
        .hold_i        (hold),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wr_data_o (mem_wr_data),
        .mem_rd_data_i (mem_rd_data),
        .rsp_vld_o     (rsp_vld),
        .rsp_data_o    (rsp_data),
        .busy_o        (busy)
    );

    // Memory samples the command at the edge after it appears; data shows up
    // one edge later, giving two cycles from mem_en to mem_rd_data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wr_data;
            else        rd_p1 <= mem[mem_addr];
        end
        mem_rd_data <= rd_p1;
    end

    task automatic idle();
        req_vld = '0;
        req_we  = '0;
        hold    = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({mem_en, mem_we, busy, rsp_vld} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got en=%b we=%b busy=%b rsp_vld=%b want all 0", mem_en, mem_we, busy, rsp_vld);
        end
        tests++;
        if ({mem_addr, mem_wr_data, rsp_data} !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wr_data, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        req_vld = 4'b0010; req_we = '0; req_addr[1] = 8'h05;
        #1;
        tests++;
        if (req_rdy !== 4'b0010) begin
            fails++;
            $display("FAIL rstmid_grant: got %b want 0010", req_rdy);
        end
        @(negedge clk); idle(); #1;
        tests++;
        if (mem_en !== 1'b1 || mem_addr !== 8'h05 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_cmd: got en=%b addr=%h busy=%b want 1 05 1", mem_en, mem_addr, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rsp_vld, mem_en, busy} !== 6'b0) begin
            fails++;
            $display("FAIL rstmid_async: got rsp_vld=%b en=%b busy=%b want 0", rsp_vld, mem_en, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if ({rsp_vld, mem_en, busy} !== 6'b0) begin
                fails++;
                $display("FAIL rstmid_after%0d: got rsp_vld=%b en=%b busy=%b want 0", c, rsp_vld, mem_en, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [12];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0001, 4'b1000, 4'b0001, 4'b1000};
        for (int k = 0; k < N; k++) begin
            req_addr[k]    = 8'h80 + 8'(k);
            req_wr_data[k] = 16'h1000 + 16'(k);
        end
        for (int i = 0; i < 12; i++) begin
            req_vld = (i < 8) ? 4'b1111 : 4'b1001;
            req_we  = 4'b1111;
            #1;
            tests++;
            if (req_rdy !== exp_seq[i]) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b want %b", i, req_rdy, exp_seq[i]);
            end
            if (i == 1) begin
                tests++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h80 || mem_wr_data !== 16'h1000) begin
                    fails++;
                    $display("FAIL rr_cmd: got en=%b we=%b addr=%h wd=%h want 1 1 80 1000", mem_en, mem_we, mem_addr, mem_wr_data);
                end
            end
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_read();
        mem[8'h10] = 16'hCAFE;
        req_vld = 4'b0100; req_we = '0; req_addr[2] = 8'h10;
        #1;
        tests++;
        if (req_rdy !== 4'b0100) begin
            fails++;
            $display("FAIL single_grant: got %b want 0100", req_rdy);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) idle();
            #1;
            if (c == 1) begin
                tests++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin
                    fails++;
                    $display("FAIL single_cmd: got en=%b we=%b addr=%h want 1 0 10", mem_en, mem_we, mem_addr);
                end
            end else if (c == 4) begin
                tests++;
                if (rsp_vld !== 4'b0100 || rsp_data !== 16'hCAFE) begin
                    fails++;
                    $display("FAIL single_rsp: got vld=%b data=%h want 0100 cafe", rsp_vld, rsp_data);
                end
            end else if (c == 5) begin
                tests++;
                if (rsp_vld !== 4'b0000 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL single_done: got vld=%b busy=%b want 0000 0", rsp_vld, busy);
                end
            end else begin
                tests++;
                if (rsp_vld !== 4'b0000) begin
                    fails++;
                    $display("FAIL single_early%0d: got vld=%b want 0000", c, rsp_vld);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mem[8'h01] = 16'h0011;
        mem[8'h02] = 16'h0022;
        req_vld = 4'b0001; req_we = '0; req_addr[0] = 8'h01;
        #1;
        tests++;
        if (req_rdy !== 4'b0001) begin
            fails++;
            $display("FAIL b2b_grant0: got %b want 0001", req_rdy);
        end
        @(negedge clk);
        req_vld = 4'b1000; req_addr[3] = 8'h02;
        #1;
        tests++;
        if (req_rdy !== 4'b1000 || mem_addr !== 8'h01) begin
            fails++;
            $display("FAIL b2b_grant3: got rdy=%b addr=%h want 1000 01", req_rdy, mem_addr);
        end
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) idle();
            #1;
            if (c == 4) begin
                tests++;
                if (rsp_vld !== 4'b0001 || rsp_data !== 16'h0011 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_rsp0: got vld=%b data=%h busy=%b want 0001 0011 1", rsp_vld, rsp_data, busy);
                end
            end else if (c == 5) begin
                tests++;
                if (rsp_vld !== 4'b1000 || rsp_data !== 16'h0022) begin
                    fails++;
                    $display("FAIL b2b_rsp3: got vld=%b data=%h want 1000 0022", rsp_vld, rsp_data);
                end
            end else if (c == 6) begin
                tests++;
                if (rsp_vld !== 4'b0000 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_idle: got vld=%b busy=%b want 0000 0", rsp_vld, busy);
                end
            end else begin
                tests++;
                if (rsp_vld !== 4'b0000) begin
                    fails++;
                    $display("FAIL b2b_early%0d: got vld=%b want 0000", c, rsp_vld);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_write_then_read();
        req_vld = 4'b0010; req_we = 4'b0010; req_addr[1] = 8'h3F; req_wr_data[1] = 16'hBEEF;
        #1;
        tests++;
        if (req_rdy !== 4'b0010) begin
            fails++;
            $display("FAIL wr_grant: got %b want 0010", req_rdy);
        end
        @(negedge clk);
        req_vld = 4'b0100; req_we = '0; req_addr[2] = 8'h3F;
        #1;
        tests++;
        if (req_rdy !== 4'b0100 || mem_we !== 1'b1 || mem_addr !== 8'h3F || mem_wr_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL wr_cmd: got rdy=%b we=%b addr=%h wd=%h want 0100 1 3f beef", req_rdy, mem_we, mem_addr, mem_wr_data);
        end
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) idle();
            #1;
            if (c == 5) begin
                tests++;
                if (rsp_vld !== 4'b0100 || rsp_data !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL wr_rd_rsp: got vld=%b data=%h want 0100 beef", rsp_vld, rsp_data);
                end
            end else begin
                tests++;
                if (rsp_vld !== 4'b0000) begin
                    fails++;
                    $display("FAIL wr_norsp%0d: got vld=%b want 0000", c, rsp_vld);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        for (int k = 0; k < N; k++) req_addr[k] = 8'h90 + 8'(k);
        req_vld = 4'b0001; req_we = '0; req_addr[0] = 8'h10;
        #1;
        tests++;
        if (req_rdy !== 4'b0001) begin
            fails++;
            $display("FAIL hold_first: got %b want 0001", req_rdy);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            hold = 1'b1; req_vld = 4'b1111; req_we = 4'b1111; req_addr[0] = 8'h90;
            #1;
            tests++;
            if (req_rdy !== 4'b0000 || (c > 1 && mem_en !== 1'b0)) begin
                fails++;
                $display("FAIL hold_c%0d: got rdy=%b en=%b want 0000 0", c, req_rdy, mem_en);
            end
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        tests++;
        if (req_rdy !== 4'b0010) begin
            fails++;
            $display("FAIL hold_resume: got %b want 0010", req_rdy);
        end
        tests++;
        if (rsp_vld !== 4'b0001 || rsp_data !== 16'hCAFE) begin
            fails++;
            $display("FAIL hold_rsp: got vld=%b data=%h want 0001 cafe", rsp_vld, rsp_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if (req_rdy !== 4'b0100) begin
            fails++;
            $display("FAIL hold_next: got %b want 0100", req_rdy);
        end
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        rd_p1       = '0;
        mem_rd_data = '0;
        req_addr    = '0;
        req_wr_data = '0;
        idle();
        test_reset();
        test_reset_mid_read();
        test_round_robin();
        test_single_read();
        test_back_to_back();
        test_write_then_read();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
